// File: rtl/screen_blit_pkg.sv
// Shared types and helpers for the screen blitter: FSM states, colour-source modes
// and geometry/latency helper functions.
package screen_blit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } blit_state_e;

  localparam logic MODE_IMAGE = 1'b0;
  localparam logic MODE_FILL  = 1'b1;

  function automatic int blit_pixels(input int w, input int h);
    return w * h;
  endfunction

  // A ROM latency below one cycle is meaningless; clamp so the delay line always exists.
  function automatic int blit_delay_depth(input int rom_lat);
    return (rom_lat < 1) ? 1 : rom_lat;
  endfunction

endpackage

// File: rtl/blit_delay_line.sv
// Fixed-depth shift register used to align pixel coordinates and valid with ROM data.
module blit_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/screen_blitter.sv
// Raster walker that plots an IMG_W x IMG_H image (from one of NUM_IMG ROMs) or a
// constant fill into the VGA write port, one pixel per cycle, with start/busy/done.
module screen_blitter
  import screen_blit_pkg::*;
#(
  parameter int IMG_W   = 240,
  parameter int IMG_H   = 240,
  parameter int X_OFF   = 80,
  parameter int Y_OFF   = 0,
  parameter int XY_W    = 9,
  parameter int CLR_W   = 3,
  parameter int NUM_IMG = 3,
  parameter int ADDR_W  = 16,
  parameter int ROM_LAT = 1,
  localparam int SEL_W  = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     fill_mode,
  input  logic [SEL_W-1:0]         img_sel,
  input  logic [CLR_W-1:0]         fill_colour,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [NUM_IMG*CLR_W-1:0] rom_q,
  output logic                     plot,
  output logic [XY_W-1:0]          xLoc,
  output logic [XY_W-1:0]          yLoc,
  output logic [CLR_W-1:0]         colour,
  output logic                     busy,
  output logic                     done
);

  localparam int N     = blit_pixels(IMG_W, IMG_H);
  localparam int DLY   = blit_delay_depth(ROM_LAT);
  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LAT_W = $clog2(DLY + 1);

  blit_state_e        state_q;
  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LAT_W-1:0]   flush_q;
  logic               busy_q;
  logic               done_q;
  logic               mode_q;
  logic [SEL_W-1:0]   sel_q;
  logic [CLR_W-1:0]   fill_q;

  logic               vld_p1;
  logic [XW-1:0]      x_p1;
  logic [YW-1:0]      y_p1;
  logic [CLR_W-1:0]   img_clr;

  // Stage p0: raster walk; the address counts linearly so no y*IMG_W product is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      flush_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= MODE_IMAGE;
      sel_q   <= '0;
      fill_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            mode_q  <= fill_mode;
            sel_q   <= (int'(img_sel) < NUM_IMG) ? img_sel : '0;
            fill_q  <= fill_colour;
          end
        end
        RUN: begin
          if (addr_q == ADDR_W'(N - 1)) begin
            state_q <= FLUSH;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            flush_q <= '0;
          end else begin
            addr_q <= addr_q + 1'b1;
            if (x_q == XW'(IMG_W - 1)) begin
              x_q <= '0;
              y_q <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flush_q == LAT_W'(DLY - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            flush_q <= flush_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Stage p1: coordinates and valid arrive in the same cycle as the ROM word.
  blit_delay_line #(
    .WIDTH (1 + XW + YW),
    .DEPTH (DLY)
  ) u_align (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   ({state_q == RUN, x_q, y_q}),
    .q_o   ({vld_p1, x_p1, y_p1})
  );

  always_comb begin
    img_clr = rom_q[CLR_W-1:0];
    for (int i = 1; i < NUM_IMG; i++) begin
      if (int'(sel_q) == i) img_clr = rom_q[i*CLR_W +: CLR_W];
    end
    plot   = vld_p1;
    xLoc   = '0;
    yLoc   = '0;
    colour = '0;
    if (vld_p1) begin
      xLoc   = XY_W'(X_OFF) + XY_W'(x_p1);
      yLoc   = XY_W'(Y_OFF) + XY_W'(y_p1);
      colour = (mode_q == MODE_FILL) ? fill_q : img_clr;
    end
  end

endmodule

// File: tb/tb_screen_blitter.sv
// Randomized scoreboard bench for screen_blitter on a small 4x3 raster with 2-cycle ROMs.
module tb_screen_blitter;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int XO  = 80;
  localparam int YO  = 5;
  localparam int XYW = 9;
  localparam int CW  = 3;
  localparam int NI  = 3;
  localparam int AW  = 4;
  localparam int LAT = 2;
  localparam int N   = W * H;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            fill_mode;
  logic [1:0]      img_sel;
  logic [CW-1:0]   fill_colour;
  logic [AW-1:0]   rom_addr;
  logic [NI*CW-1:0] rom_q;
  logic            plot;
  logic [XYW-1:0]  xLoc;
  logic [XYW-1:0]  yLoc;
  logic [CW-1:0]   colour;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  screen_blitter #(
    .IMG_W(W), .IMG_H(H), .X_OFF(XO), .Y_OFF(YO), .XY_W(XYW),
    .CLR_W(CW), .NUM_IMG(NI), .ADDR_W(AW), .ROM_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .fill_mode(fill_mode),
    .img_sel(img_sel), .fill_colour(fill_colour), .rom_addr(rom_addr),
    .rom_q(rom_q), .plot(plot), .xLoc(xLoc), .yLoc(yLoc), .colour(colour),
    .busy(busy), .done(done)
  );

  // Synchronous image ROMs with LAT cycles of read latency.
  logic [CW-1:0] mem [NI][16];
  logic [AW-1:0] apipe [LAT];

  always @(posedge clk) begin
    apipe[0] <= rom_addr;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end

  always_comb begin
    for (int i = 0; i < NI; i++) rom_q[i*CW +: CW] = mem[i][apipe[LAT-1]];
  end

  typedef struct {
    int cyc;
    int x;
    int y;
    int clr;
  } exp_t;

  exp_t pq[$];
  int   dq[$];
  int   cyc      = 0;
  int   free_cyc = 0;
  int   busy_lo  = 0;
  int   busy_hi  = -1;
  int   run_base = -100;
  int   n_tests  = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  function automatic int exp_clr(input logic fm, input logic [CW-1:0] fc,
                                 input logic [1:0] sel, input int k);
    int s;
    s = (int'(sel) < NI) ? int'(sel) : 0;
    return fm ? int'(fc) : int'(mem[s][k]);
  endfunction

  task automatic chk(input bit ok, input string name, input string got, input string want);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %s want %s", name, cyc, got, want);
    end
  endtask

  // Reference model: a draw accepted at cycle c plots pixel k at c+1+k+LAT, done at c+N+LAT+1.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        pq.delete();
        dq.delete();
        busy_lo  = 0;
        busy_hi  = -1;
        run_base = -100;
        free_cyc = cyc + 1;
      end else if (start && cyc >= free_cyc) begin
        for (int k = 0; k < N; k++)
          pq.push_back(exp_t'{cyc + 1 + k + LAT, XO + k % W, YO + k / W,
                              exp_clr(fill_mode, fill_colour, img_sel, k)});
        dq.push_back(cyc + N + LAT + 1);
        busy_lo  = cyc + 1;
        busy_hi  = cyc + N + LAT;
        run_base = cyc + 1;
        free_cyc = cyc + N + LAT + 2;
      end
      cyc = cyc + 1;
    end
  end

  // Monitor: compares DUT outputs against the scoreboard every cycle.
  initial begin
    exp_t e;
    int   want_addr;
    int   dc;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (plot) begin
          if (pq.size() == 0) begin
            chk(1'b0, "extra_plot", $sformatf("(%0d,%0d,c%0d)", xLoc, yLoc, colour), "no plot");
          end else begin
            e = pq.pop_front();
            chk(e.cyc == cyc && int'(xLoc) == e.x && int'(yLoc) == e.y && int'(colour) == e.clr,
                "plot",
                $sformatf("cyc%0d (%0d,%0d,c%0d)", cyc, xLoc, yLoc, colour),
                $sformatf("cyc%0d (%0d,%0d,c%0d)", e.cyc, e.x, e.y, e.clr));
          end
        end else begin
          chk(xLoc == '0 && yLoc == '0 && colour == '0, "idle_zero",
              $sformatf("(%0d,%0d,c%0d)", xLoc, yLoc, colour), "(0,0,c0)");
          if (pq.size() != 0 && pq[0].cyc <= cyc) begin
            e = pq.pop_front();
            chk(1'b0, "missing_plot", "no plot", $sformatf("(%0d,%0d) at cyc%0d", e.x, e.y, e.cyc));
          end
        end
        chk(busy == (cyc >= busy_lo && cyc <= busy_hi), "busy",
            $sformatf("%0b", busy), $sformatf("%0b", (cyc >= busy_lo && cyc <= busy_hi)));
        want_addr = (cyc >= run_base && cyc < run_base + N) ? cyc - run_base : 0;
        chk(int'(rom_addr) == want_addr, "rom_addr",
            $sformatf("%0d", rom_addr), $sformatf("%0d", want_addr));
        if (done) begin
          if (dq.size() == 0) begin
            chk(1'b0, "extra_done", "done=1", "done=0");
          end else begin
            dc = dq.pop_front();
            chk(dc == cyc, "done_cycle", $sformatf("%0d", cyc), $sformatf("%0d", dc));
            chk(pq.size() == 0, "plots_left_at_done",
                $sformatf("%0d", pq.size()), "0");
          end
        end else if (dq.size() != 0 && dq[0] <= cyc) begin
          dc = dq.pop_front();
          chk(1'b0, "missing_done", "done=0", $sformatf("done at cyc%0d", dc));
        end
      end
    end
  end

  task automatic scramble();
    fill_mode   = 1'($urandom);
    img_sel     = 2'($urandom);
    fill_colour = CW'($urandom);
  endtask

  task automatic draw(input logic fm, input logic [1:0] sel, input logic [CW-1:0] fc);
    fill_mode   = fm;
    img_sel     = sel;
    fill_colour = fc;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((pq.size() != 0 || dq.size() != 0) && n < lim) begin
      scramble();
      @(negedge clk);
      n++;
    end
    if (n >= lim) chk(1'b0, "drain_timeout", $sformatf("%0d pending", pq.size() + dq.size()), "0");
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NI; i++)
      for (int a = 0; a < 16; a++) mem[i][a] = CW'($urandom);
    reset       = 1'b1;
    start       = 1'b0;
    fill_mode   = 1'b0;
    img_sel     = '0;
    fill_colour = '0;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    draw(1'b1, 2'd0, 3'b001);
    drain(200);
    for (int s = 0; s < 4; s++) begin
      draw(1'b0, 2'(s), CW'($urandom));
      drain(200);
    end
    draw(1'b1, 2'd1, 3'b110);
    drain(200);

    // Abort mid-draw, then a fresh draw must complete in full.
    draw(1'b0, 2'd2, 3'b000);
    repeat (4) begin
      scramble();
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    draw(1'b0, 2'd1, 3'b000);
    drain(200);

    // start held high with inputs changing every cycle: back-to-back draws.
    start = 1'b1;
    repeat (4 * (N + LAT + 2) + 3) begin
      scramble();
      @(negedge clk);
    end
    start = 1'b0;
    drain(200);

    repeat (400) begin
      scramble();
      start = ($urandom % 4) == 0;
      reset = ($urandom % 97) == 0;
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    drain(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/screen_blitter.md
Name: screen_blitter

Overview:
- Parametrised full-screen image/fill drawer feeding the VGA adapter write port.
- On a start pulse it walks an IMG_W x IMG_H raster and emits one plot per pixel at (X_OFF+x, Y_OFF+y).
- Pixel colour comes either from one of NUM_IMG external synchronous image ROMs (image mode) or from a constant (fill mode).
- Successor to the fixed 240x240 three-image screen drawer: adds geometry parameters, configurable ROM latency, explicit start/busy/done handshake and a plot strobe.

Parameters:
- IMG_W, 240, raster width in pixels
- IMG_H, 240, raster height in pixels
- X_OFF, 80, screen x of raster column 0
- Y_OFF, 0, screen y of raster row 0
- XY_W, 9, width of xLoc/yLoc
- CLR_W, 3, colour width
- NUM_IMG, 3, number of image ROMs
- ADDR_W, 16, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- ROM_LAT, 1, ROM read latency in cycles (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a draw; sampled only in IDLE
- fill_mode  in  1  1 = constant fill, 0 = image
- img_sel  in  $clog2(NUM_IMG)  image index for image mode
- fill_colour  in  CLR_W  colour for fill mode
- rom_addr  out  ADDR_W  shared address to all image ROMs
- rom_q  in  NUM_IMG*CLR_W  packed ROM outputs; image i at bits [i*CLR_W +: CLR_W]
- plot  out  1  VGA write enable
- xLoc  out  XY_W  screen x
- yLoc  out  XY_W  screen y
- colour  out  CLR_W  pixel colour
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (any state, including mid-draw): state IDLE; x, y and rom_addr at 0; plot, busy and done at 0; xLoc, yLoc and colour at 0. No done pulse is issued for an aborted draw.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - Edge with start=1 → RUN.
  - Latch fill_mode, img_sel and fill_colour; later changes are ignored until the next IDLE.
  - img_sel >= NUM_IMG is treated as 0.
- RUN:
  - Each cycle presents pixel (x,y), with rom_addr = y*IMG_W + x.
  - rom_addr is kept as an incrementing register; no multiplier.
  - x increments each cycle. At x = IMG_W-1, x wraps to 0 and y increments.
  - At the last pixel (x = IMG_W-1, y = IMG_H-1) → FLUSH; x, y and rom_addr return to 0.
- FLUSH: holds for ROM_LAT cycles while the pipeline drains, then → DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then → IDLE. start is ignored in DONE.
- Output pipeline:
  - x, y and a valid bit are delayed ROM_LAT cycles to align with rom_q.
  - The plot/xLoc/yLoc/colour register stage adds no further latency beyond that alignment.
  - Pixel k (k = y*IMG_W + x) is presented at cycle 1+k after start is accepted at cycle 0, and plotted at cycle 1+k+ROM_LAT.
  - With N = IMG_W*IMG_H, done occurs at cycle N+ROM_LAT+1.
  - Exactly N plot pulses per draw, contiguous, in raster order.
- Colour:
  - Fill mode: colour = latched fill_colour. Latency is identical to image mode.
  - Image mode: colour = selected slice of rom_q.
- Output values:
  - plot=0 ⇒ xLoc, yLoc and colour are 0.
  - xLoc = X_OFF + x and yLoc = Y_OFF + y, computed at XY_W width and truncated on overflow. The integrator guarantees fit.
- busy is high in RUN and FLUSH only; start is ignored while busy.
- The block never stalls; the downstream write port must accept one pixel per cycle.

Decomposition:
- Package screen_blit_pkg holds:
  - state enum (IDLE, RUN, FLUSH, DONE);
  - MODE_IMAGE / MODE_FILL constants;
  - localparam helpers for N and the ROM_LAT delay depth.
- One sub-module: blit_delay_line.
  - Parameters: WIDTH and DEPTH; holds a shift register with synchronous clear on reset.
  - Used to carry {valid, x, y} ROM_LAT cycles.

Test Plan:
- IMG_W=4, IMG_H=3, X_OFF=80, Y_OFF=0, ROM_LAT=1, fill_mode=1, fill_colour=3'b001, start at cycle 0 → 12 plots at cycles 2..13, (80,0),(81,0)..(83,2), all colour 001; done only at cycle 14; busy cycles 1..13.
- Same geometry, image mode, img_sel=2, ROM model returning addr[2:0] on slice 2 and 0 elsewhere, ROM_LAT=2 → plot k carries colour k mod 8; first plot at cycle 3; done at cycle 15.
- Reset asserted at cycle 6 of a draw → plot, busy, xLoc, yLoc and colour are 0 the next cycle; no done pulse; a new start then yields a full 12 plots from (80,0).
- start held high continuously with img_sel toggling every cycle → draws back-to-back, each separated by DONE then IDLE; each uses the img_sel latched at its own accept; never more than 12 plots per done.
- img_sel=3 with NUM_IMG=3 → draws from image 0.
- Default parameters, fill → exactly 57600 plots; last plot at (319,239); done at cycle 57602.
